// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the pipelined adder slice.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_LANE  = 4;

  // Number of register stages for a given operand width and slice width.
  // Guarded so a degenerate parameter set still elaborates a single stage.
  function automatic int stage_count(input int width, input int lane);
    if (lane <= 0 || width <= lane) begin
      return 1;
    end
    return width / lane;
  endfunction

  // Lowest bit index of slice k.
  function automatic int slice_lo(input int k, input int lane);
    return k * lane;
  endfunction

endpackage

// File: rtl/pipelined_adder_full_adder.sv
// One-bit full adder built from two half-adder equations; the ripple
// element of every pipeline slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs1;
  logic hc1;
  logic hc2;

  // First half adder: a + b.
  assign hs1 = a ^ b;
  assign hc1 = a & b;

  // Second half adder: partial sum + carry-in.
  assign s   = hs1 ^ ci;
  assign hc2 = hs1 & ci;

  // A carry can come from either half adder, never both.
  assign co  = hc1 | hc2;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into LANE-bit slices, one slice per register stage,
// with valid/ready on both sides. Each stage carries forward the finished
// low sum bits, its carry, and the not-yet-added high slices of a and b.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LANE  = DEFAULT_LANE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = stage_count(WIDTH, LANE);

  // Stage state. Index k is the register stage that has finished slice k.
  logic [STAGES-1:0] valid_q;
  logic              carry_q [STAGES];
  logic [WIDTH-1:0]  sum_q   [STAGES];
  logic [WIDTH-1:0]  rem_a_q [STAGES];
  logic [WIDTH-1:0]  rem_b_q [STAGES];
  logic              ovf_q;

  // Handshake chain: ready[k] says stage k may load this cycle.
  logic [STAGES:0]   ready;
  // Valid bit offered to each stage: in_valid for stage 0, else the stage before.
  logic [STAGES-1:0] feed_valid;

  // Ready ripples back from the sink: a stage can load if it is empty or
  // its contents move on this same cycle.
  // NOTE: blocking assignments in always_comb; each bit is computed from the
  // one above it in program order, and every bit is written on every pass,
  // so no latch can be inferred.
  always_comb begin
    ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready[k] = ~valid_q[k] | ready[k+1];
    end
  end

  assign feed_valid = STAGES'({valid_q, in_valid});

  // Valid bits: a loading stage takes its upstream valid, a stalled stage holds.
  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of its neighbour and the whole pipe advances together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= (valid_q & ~ready[STAGES-1:0]) | (feed_valid & ready[STAGES-1:0]);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] part_sum;
    logic             cin_k;
    logic             load;
    logic [LANE-1:0]  lane_sum;
    logic             lane_cout;

    if (k == 0) begin : gen_first
      assign op_a     = a;
      assign op_b     = b;
      assign part_sum = '0;
      assign cin_k    = cin;
      assign load     = in_valid & ready[0];
    end else begin : gen_next
      assign op_a     = rem_a_q[k-1];
      assign op_b     = rem_b_q[k-1];
      assign part_sum = sum_q[k-1];
      assign cin_k    = carry_q[k-1];
      assign load     = valid_q[k-1] & ready[k];
    end

    // Ripple-carry across the slice; each bit owns its carry-out so the
    // chain is a series of distinct nets rather than one self-feeding vector.
    for (genvar j = 0; j < LANE; j++) begin : gen_bit
      logic ci;
      logic co;

      if (j == 0) begin : gen_c0
        assign ci = cin_k;
      end else begin : gen_cn
        assign ci = gen_bit[j-1].co;
      end

      full_adder u_fa (
        .a  (op_a[j]),
        .b  (op_b[j]),
        .ci (ci),
        .s  (lane_sum[j]),
        .co (co)
      );
    end

    assign lane_cout = gen_bit[LANE-1].co;

    // Capture this slice's result, its carry, and shift the remaining
    // operand slices down so the next stage always adds bits [LANE-1:0].
    // NOTE: the data registers are reset as well as the valid bits, so sum,
    // cout and ovf read zero during and straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        rem_a_q[k] <= '0;
        rem_b_q[k] <= '0;
      end else if (load) begin
        sum_q[k]   <= part_sum | (WIDTH'(lane_sum) << slice_lo(k, LANE));
        carry_q[k] <= lane_cout;
        rem_a_q[k] <= op_a >> LANE;
        rem_b_q[k] <= op_b >> LANE;
      end
    end

    if (k == STAGES - 1) begin : gen_ovf
      // The top slice holds the sign bits of a, b and the sum: signed
      // overflow is equal operand signs with a different result sign.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (load) begin
          ovf_q <= (op_a[LANE-1] == op_b[LANE-1]) && (lane_sum[LANE-1] != op_a[LANE-1]);
        end
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder. Three instances (8/4, 16/4, 4/4)
// share one stimulus stream; a per-instance scoreboard holds the expected
// results from an arithmetic reference model and checks order, values and
// (while the sink never stalls) the exact latency of every result.
module tb_pipelined_adder;

  localparam int NDUT = 3;
  localparam int WID [NDUT] = '{8, 16, 4};
  localparam int STG [NDUT] = '{2, 4, 1};

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic        cin       = 1'b0;
  logic [15:0] a16       = '0;
  logic [15:0] b16       = '0;

  logic        in_ready0, out_valid0, cout0, ovf0;
  logic [7:0]  sum0;
  logic        in_ready1, out_valid1, cout1, ovf1;
  logic [15:0] sum1;
  logic        in_ready2, out_valid2, cout2, ovf2;
  logic [3:0]  sum2;

  logic        o_valid [NDUT];
  logic        i_ready [NDUT];
  logic        o_cout  [NDUT];
  logic        o_ovf   [NDUT];
  logic [15:0] o_sum   [NDUT];

  exp_t sb [NDUT][$];
  int   acc_n  [NDUT];
  int   emit_n [NDUT];
  int   base_n [NDUT];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   no_bp = 1'b1;

  pipelined_adder #(.WIDTH(8), .LANE(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a16[7:0]), .b(b16[7:0]), .cin(cin),
    .out_valid(out_valid0), .out_ready(out_ready),
    .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  pipelined_adder #(.WIDTH(16), .LANE(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a16), .b(b16), .cin(cin),
    .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  pipelined_adder #(.WIDTH(4), .LANE(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a16[3:0]), .b(b16[3:0]), .cin(cin),
    .out_valid(out_valid2), .out_ready(out_ready),
    .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  assign o_valid[0] = out_valid0;
  assign o_valid[1] = out_valid1;
  assign o_valid[2] = out_valid2;
  assign i_ready[0] = in_ready0;
  assign i_ready[1] = in_ready1;
  assign i_ready[2] = in_ready2;
  assign o_cout[0]  = cout0;
  assign o_cout[1]  = cout1;
  assign o_cout[2]  = cout2;
  assign o_ovf[0]   = ovf0;
  assign o_ovf[1]   = ovf1;
  assign o_ovf[2]   = ovf2;
  assign o_sum[0]   = {8'h00, sum0};
  assign o_sum[1]   = sum1;
  assign o_sum[2]   = {12'h000, sum2};

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp accepts and emits.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic and the two's-complement sign rule.
  function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input logic c);
    exp_t                  e;
    longint unsigned       mask;
    longint unsigned       total;
    longint unsigned       sx, sy, ss;
    mask   = (64'd1 << w) - 64'd1;
    total  = ({48'd0, x} & mask) + ({48'd0, y} & mask) + {63'd0, c};
    sx     = ({48'd0, x} >> (w - 1)) & 64'd1;
    sy     = ({48'd0, y} >> (w - 1)) & 64'd1;
    ss     = (total >> (w - 1)) & 64'd1;
    e.sum  = 16'(total & mask);
    e.cout = ((total >> w) & 64'd1) != 0;
    e.ovf  = (sx == sy) && (ss != sx);
    e.acc  = 0;
    return e;
  endfunction

  // Scoreboard: record every accepted operand set, check every emitted result.
  // Handshakes are sampled on the falling edge, half a cycle before the
  // rising edge at which the transfer actually happens.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      for (int d = 0; d < NDUT; d++) begin
        if (in_valid && i_ready[d]) begin
          e     = model(WID[d], a16, b16, cin);
          e.acc = cyc;
          sb[d].push_back(e);
          acc_n[d]++;
        end
        if (o_valid[d] && out_ready) begin
          if (sb[d].size() == 0) begin
            check($sformatf("dut%0d_unexpected_output", d), 32'd1, 32'd0);
          end else begin
            e = sb[d].pop_front();
            check($sformatf("dut%0d_sum", d),  32'(o_sum[d]),  32'(e.sum));
            check($sformatf("dut%0d_cout", d), 32'(o_cout[d]), 32'(e.cout));
            check($sformatf("dut%0d_ovf", d),  32'(o_ovf[d]),  32'(e.ovf));
            if (no_bp) begin
              check($sformatf("dut%0d_latency", d), 32'(cyc - e.acc), 32'(STG[d]));
            end
            emit_n[d]++;
          end
        end
      end
    end
  end

  // One beat on dut0 with an idle pipe, result checked against constants.
  task automatic directed(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic [7:0] es, input logic ec, input logic eo);
    @(posedge clk); #1;
    in_valid = 1'b1;
    a16      = {8'h00, ta};
    b16      = {8'h00, tb};
    cin      = tc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (STG[0] - 1) @(posedge clk);
    @(negedge clk);
    check("dir_out_valid", 32'(out_valid0), 32'd1);
    check("dir_sum",       32'(sum0),       32'(es));
    check("dir_cout",      32'(cout0),      32'(ec));
    check("dir_ovf",       32'(ovf0),       32'(eo));
  endtask

  task automatic randomize_operands();
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    cin = 1'($urandom);
  endtask

  // n cycles of random operands with the given valid/ready probabilities (percent).
  task automatic drive_random(input int n, input int iv_pct, input int or_pct);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(99) < iv_pct);
      out_ready = ($urandom_range(99) < or_pct);
      randomize_operands();
    end
  endtask

  // Stop input, open the sink, and wait (bounded) until every scoreboard is empty.
  task automatic drain();
    int t;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (t < 64 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("dut%0d_emit_count", d), 32'(emit_n[d]), 32'(acc_n[d]));
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] held;
    held = '0;
    for (int d = 0; d < NDUT; d++) begin
      acc_n[d]  = 0;
      emit_n[d] = 0;
      base_n[d] = 0;
    end

    // Power-on reset: outputs idle while rst_n is low.
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid0", 32'(out_valid0), 32'd0);
    check("rst_sum0",       32'(sum0),       32'd0);
    check("rst_cout0",      32'(cout0),      32'd0);
    check("rst_ovf0",       32'(ovf0),       32'd0);
    check("rst_out_valid1", 32'(out_valid1), 32'd0);
    check("rst_out_valid2", 32'(out_valid2), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready0",  32'(in_ready0),  32'd1);
    check("post_rst_out_valid0", 32'(out_valid0), 32'd0);

    // Directed corner cases on the 8-bit instance.
    directed(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    directed(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    directed(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    directed(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    drain();

    // 256 back-to-back random beats with an always-ready sink.
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      randomize_operands();
      @(negedge clk);
      check("stream_in_ready0", 32'(in_ready0), 32'd1);
      if (i >= STG[0]) check("stream_out_valid0", 32'(out_valid0), 32'd1);
      if (i >= STG[1]) check("stream_out_valid1", 32'(out_valid1), 32'd1);
    end
    drain();

    // Sink stalled from an empty pipe: each instance takes exactly STAGES
    // beats, then in_ready drops and the head result holds still.
    no_bp = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int d = 0; d < NDUT; d++) base_n[d] = acc_n[d];
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      randomize_operands();
      @(negedge clk);
      if (i >= 2) begin
        check("hold_out_valid0", 32'(out_valid0), 32'd1);
        check("hold_sum0_head",  32'(sum0),       32'(sb[0][0].sum));
        if (i > 2) check("hold_sum0_stable", 32'(sum0), 32'(held));
        held = sum0;
      end
    end
    check("full_in_ready0", 32'(in_ready0), 32'd0);
    check("full_in_ready1", 32'(in_ready1), 32'd0);
    check("full_in_ready2", 32'(in_ready2), 32'd0);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("dut%0d_fill_count", d), 32'(acc_n[d] - base_n[d]), 32'(STG[d]));
    end
    drain();

    // Stall in the middle of a full-rate stream.
    drive_random(12, 100, 100);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      randomize_operands();
      @(negedge clk);
      check("stall_in_ready0",  32'(in_ready0),  32'd0);
      check("stall_out_valid0", 32'(out_valid0), 32'd1);
    end
    drive_random(10, 100, 100);
    drain();

    // Random valid and ready on both sides.
    drive_random(300, 75, 70);
    drain();
    no_bp = 1'b1;

    // Reset in the middle of a stream: everything in flight is discarded.
    drive_random(10, 100, 100);
    @(posedge clk);
    #3 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid0", 32'(out_valid0), 32'd0);
    check("midrst_sum0",       32'(sum0),       32'd0);
    check("midrst_cout0",      32'(cout0),      32'd0);
    check("midrst_ovf0",       32'(ovf0),       32'd0);
    check("midrst_out_valid1", 32'(out_valid1), 32'd0);
    check("midrst_out_valid2", 32'(out_valid2), 32'd0);
    for (int d = 0; d < NDUT; d++) begin
      sb[d].delete();
      acc_n[d]  = 0;
      emit_n[d] = 0;
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_out_valid0", 32'(out_valid0), 32'd0);
      check("no_stale_out_valid1", 32'(out_valid1), 32'd0);
      check("no_stale_out_valid2", 32'(out_valid2), 32'd0);
    end
    check("midrst_in_ready0", 32'(in_ready0), 32'd1);

    // Still adds correctly after the mid-stream reset.
    directed(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
